// File: rtl/led_row_scanner_pkg.sv
// led_row_scanner_pkg: shared matrix constants, scan states and row-rotation helper
package led_row_scanner_pkg;
    localparam int MATRIX_ROWS = 8;
    localparam logic [7:0] ROW0_ONEHOT = 8'h01;
    localparam logic [7:0] ROW_LAST_ONEHOT = 8'h80;
    typedef enum logic [1:0] {IDLE = 2'd0, BLANK = 2'd1, SHOW = 2'd2} scan_state_t;
    // A corrupted (non-one-hot) select falls back to row 0 instead of rotating.
    function automatic logic [7:0] next_row(input logic [7:0] r);
        logic hot;
        hot = (r != 8'h00) && ((r & (r - 8'h01)) == 8'h00);
        return !hot ? ROW0_ONEHOT : (r == ROW_LAST_ONEHOT) ? ROW0_ONEHOT : {r[6:0], 1'b0};
    endfunction
endpackage

// File: rtl/led_row_scanner_timer.sv
// scan_phase_timer: clearable up-counter flagging when it reaches the phase's last cycle
module scan_phase_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [W-1:0] last,
    output logic [W-1:0] cnt,
    output logic         tc
);
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else     cnt <= clr ? '0 : cnt + 1'b1;
    assign tc = (cnt == last);
endmodule

// File: rtl/led_row_scanner.sv
// led_row_scanner: blank/show row scanner for the 8x8 snake LED matrix
// Optional brightness control via SCAN_DIM_EN (adds the 2-bit dim input).
module led_row_scanner
    import led_row_scanner_pkg::*;
#(
    parameter int BLANK_CYCLES = 4,
    parameter int SHOW_CYCLES  = 5000,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
`ifdef SCAN_DIM_EN
    input  logic [1:0] dim,
`endif
    input  logic [7:0] col_data_in,
    output logic [7:0] row_sel,
    output logic [7:0] col_out,
    output logic       row_blank,
    output logic       row_strobe,
    output logic       frame_start
);
    scan_state_t state, state_n;
    logic [7:0] row_sel_n, col_n;
    logic blank_n, strobe_n, frame_n, tc;
    logic [CNT_W-1:0] cnt;
    logic [31:0] thr;
`ifdef SCAN_DIM_EN
    logic [1:0] dim_q;
    always_ff @(posedge clk or posedge rst)
        if (rst)                                    dim_q <= 2'd0;
        else if (en && state == BLANK && tc)        dim_q <= dim;
    assign thr = 32'(SHOW_CYCLES) - ((32'(dim_q) * 32'(SHOW_CYCLES)) >> 2);
`else
    assign thr = 32'(SHOW_CYCLES);
`endif
    scan_phase_timer #(.W(CNT_W)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_n != state || state == IDLE),
        .last (state == BLANK ? CNT_W'(BLANK_CYCLES - 1) : CNT_W'(SHOW_CYCLES - 1)),
        .cnt  (cnt),
        .tc   (tc)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state       <= IDLE;
            row_sel     <= ROW0_ONEHOT;
            col_out     <= 8'h00;
            row_blank   <= 1'b1;
            row_strobe  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_n;
            row_sel     <= row_sel_n;
            col_out     <= col_n;
            row_blank   <= blank_n;
            row_strobe  <= strobe_n;
            frame_start <= frame_n;
        end
    // Outputs are computed for the next cycle, so dimming compares against cnt+1.
    always_comb begin
        state_n   = state;
        row_sel_n = row_sel;
        col_n     = col_out;
        blank_n   = row_blank;
        strobe_n  = 1'b0;
        frame_n   = 1'b0;
        if (!en) begin
            state_n   = IDLE;
            row_sel_n = ROW0_ONEHOT;
            col_n     = 8'h00;
            blank_n   = 1'b1;
        end else begin
            case (state)
                IDLE: state_n = BLANK;
                BLANK: begin
                    col_n   = tc ? col_data_in : 8'h00;
                    blank_n = !tc;
                    strobe_n = tc;
                    frame_n  = tc && (row_sel == ROW0_ONEHOT);
                    state_n  = tc ? SHOW : BLANK;
                end
                SHOW: begin
                    if (tc) begin
                        state_n   = BLANK;
                        col_n     = 8'h00;
                        blank_n   = 1'b1;
                        row_sel_n = next_row(row_sel);
                    end else if (32'(cnt) + 32'd1 >= thr) begin
                        col_n   = 8'h00;
                        blank_n = 1'b1;
                    end
                end
                default: begin
                    state_n   = IDLE;
                    row_sel_n = ROW0_ONEHOT;
                    col_n     = 8'h00;
                    blank_n   = 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_led_row_scanner.sv
// tb_led_row_scanner: directed checks of row scanning, timing, disable and async reset
module tb_led_row_scanner;
    logic clk = 1'b0, rst = 1'b1, en = 1'b0;
    logic [7:0] row_sel, col_out, col_data_in;
    logic row_blank, row_strobe, frame_start;
    int passes = 0, total = 0;
    always #5 clk = ~clk;
    assign col_data_in = row_sel ^ 8'hFF;

    led_row_scanner #(.BLANK_CYCLES(2), .SHOW_CYCLES(3), .CNT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
`ifdef SCAN_DIM_EN
        .dim         (2'd0),
`endif
        .col_data_in (col_data_in),
        .row_sel     (row_sel),
        .col_out     (col_out),
        .row_blank   (row_blank),
        .row_strobe  (row_strobe),
        .frame_start (frame_start)
    );

`ifdef SCAN_DIM_EN
    logic [7:0] d_row, d_col;
    logic d_blank, d_strobe, d_frame, dim_cnt_en = 1'b0;
    int dim_on = 0;
    led_row_scanner #(.BLANK_CYCLES(2), .SHOW_CYCLES(8), .CNT_W(4)) u_dim (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .dim         (2'd2),
        .col_data_in (d_row ^ 8'hFF),
        .row_sel     (d_row),
        .col_out     (d_col),
        .row_blank   (d_blank),
        .row_strobe  (d_strobe),
        .frame_start (d_frame)
    );
`endif

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
`ifdef SCAN_DIM_EN
        if (dim_cnt_en && d_col != 8'h00) dim_on++;
`endif
    endtask

    initial begin
        int e;
        logic [7:0] exp_row;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_row_sel", row_sel, 8'h01);
        chk("rst_col_out", col_out, 8'h00);
        chk("rst_blank", 8'(row_blank), 8'h01);
        repeat (20) begin
            step();
            chk("idle_row_sel", row_sel, 8'h01);
            chk("idle_col_out", col_out, 8'h00);
            chk("idle_blank", 8'(row_blank), 8'h01);
            chk("idle_pulses", {6'd0, row_strobe, frame_start}, 8'h00);
        end
        en = 1'b1;
`ifdef SCAN_DIM_EN
        dim_cnt_en = 1'b1;
`endif
        step();
        chk("e0_blank", 8'(row_blank), 8'h01);
        chk("e0_col", col_out, 8'h00);
        step();
        chk("e1_strobe", 8'(row_strobe), 8'h00);
        step();
        chk("e2_strobe", 8'(row_strobe), 8'h01);
        chk("e2_frame", 8'(frame_start), 8'h01);
        chk("e2_col", col_out, 8'hFE);
        chk("e2_blank", 8'(row_blank), 8'h00);
        step();
        chk("e3_strobe", 8'(row_strobe), 8'h00);
        chk("e3_frame", 8'(frame_start), 8'h00);
        chk("e3_col", col_out, 8'hFE);
        step();
        step();
        chk("e5_row", row_sel, 8'h02);
        chk("e5_col", col_out, 8'h00);
        chk("e5_blank", 8'(row_blank), 8'h01);
        step();
        step();
        chk("e7_strobe", 8'(row_strobe), 8'h01);
        chk("e7_frame", 8'(frame_start), 8'h00);
        chk("e7_col", col_out, 8'hFD);
        e = 7;
        exp_row = 8'h04;
        repeat (35) begin
            step();
            e++;
`ifdef SCAN_DIM_EN
            if (e == 40) dim_cnt_en = 1'b0;
`endif
            chk("wrap_strobe", 8'(row_strobe), 8'(((e - 2) % 5) == 0));
            chk("wrap_frame", 8'(frame_start), 8'(e == 42));
            if ((e - 2) % 5 == 0) begin
                chk("wrap_row", row_sel, exp_row);
                chk("wrap_col", col_out, exp_row ^ 8'hFF);
                exp_row = (exp_row == 8'h80) ? 8'h01 : {exp_row[6:0], 1'b0};
            end
        end
        chk("wrap_end_row", row_sel, 8'h01);
`ifdef SCAN_DIM_EN
        chk("dim_on_cycles", 8'(dim_on), 8'd16);
`endif
        repeat (20) step();
        chk("e62_row", row_sel, 8'h10);
        chk("e62_strobe", 8'(row_strobe), 8'h01);
        en = 1'b0;
        step();
        chk("dis_col", col_out, 8'h00);
        chk("dis_blank", 8'(row_blank), 8'h01);
        chk("dis_row", row_sel, 8'h01);
        en = 1'b1;
        step();
        step();
        chk("reen_nostrobe", 8'(row_strobe), 8'h00);
        step();
        chk("reen_strobe", 8'(row_strobe), 8'h01);
        chk("reen_frame", 8'(frame_start), 8'h01);
        chk("reen_row", row_sel, 8'h01);
        chk("reen_col", col_out, 8'hFE);
        step();
        step();
        step();
        chk("show_row2", row_sel, 8'h02);
        step();
        step();
        step();
        chk("show2_col", col_out, 8'hFD);
        #1 rst = 1'b1;
        #1;
        chk("arst_col", col_out, 8'h00);
        chk("arst_blank", 8'(row_blank), 8'h01);
        chk("arst_row", row_sel, 8'h01);
        chk("arst_pulses", {6'd0, row_strobe, frame_start}, 8'h00);
        rst = 1'b0;
        @(negedge clk);
        step();
        en = 1'b0;
        step();
        en = 1'b1;
        step();
        chk("toggle_blank", 8'(row_blank), 8'h01);
        chk("toggle_col", col_out, 8'h00);
        step();
        chk("toggle_nostrobe", 8'(row_strobe), 8'h00);
        step();
        chk("toggle_strobe", 8'(row_strobe), 8'h01);
        chk("toggle_row", row_sel, 8'h01);
        chk("toggle_col2", col_out, 8'hFE);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
